pipelined_instruction_decoder: RTL and testbench

Parametrised, handshaked successor to the per-core instruction decoder. It takes raw instructions from the fetcher over a valid/ready interface and registers the decoded field and control bundle. A two-entry skid buffer feeds the execute stage over a second valid/ready interface, sustaining one instruction per cycle under backpressure. It adds:
- configurable field widths;
- sign-extended immediates;
- illegal-opcode flagging;
- pipeline flush for branches and jumps.

---
 rtl/decoder_pkg.sv | 55 +++++
 rtl/decode_ctrl_gen.sv | 102 ++++++++++
 rtl/pipelined_instruction_decoder.sv | 133 +++++++++++++
 tb/tb_pipelined_instruction_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the pipelined instruction decoder.
// Holds the opcode map, the mux encodings and the decoded bundle type.
// Bundle field widths are upper bounds on the module parameters. Each instance
// zero-pads (or sign-extends) into them and slices its own width back out.
package decoder_pkg;

    localparam int unsigned MAX_REG_ADDR_WIDTH = 8;
    localparam int unsigned MAX_DATA_WIDTH     = 32;

    // Opcodes (low four opcode bits)
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_BRNZP = 4'h1;
    localparam logic [3:0] OP_CMP   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_LDR   = 4'h7;
    localparam logic [3:0] OP_STR   = 4'h8;
    localparam logic [3:0] OP_CONST = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_RET   = 4'hF;

    localparam logic [1:0] PC_MUX_NEXT   = 2'd0;
    localparam logic [1:0] PC_MUX_BRANCH = 2'd1;
    localparam logic [1:0] PC_MUX_JUMP   = 2'd2;

    localparam logic [1:0] REG_IN_ALU = 2'b00;
    localparam logic [1:0] REG_IN_MEM = 2'b01;
    localparam logic [1:0] REG_IN_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    typedef struct packed {
        logic [MAX_REG_ADDR_WIDTH-1:0] rd_address;
        logic [MAX_REG_ADDR_WIDTH-1:0] rs_address;
        logic [MAX_REG_ADDR_WIDTH-1:0] rt_address;
        logic [2:0]                    nzp;
        logic [MAX_DATA_WIDTH-1:0]     immediate;
        logic                          reg_write_enable;
        logic                          mem_read_enable;
        logic                          mem_write_enable;
        logic                          nzp_write_enable;
        logic [1:0]                    reg_input_mux;
        logic [1:0]                    alu_arithmetic_mux;
        logic                          alu_output_mux;
        logic [1:0]                    pc_mux;
        logic                          ret;
        logic                          illegal;
    } decode_bundle_t;

endpackage

// File: rtl/decode_ctrl_gen.sv
// Combinational instruction decoder: raw instruction -> decode_bundle_t.
// Ports:
//   instruction  in   raw instruction word
//   bundle       out  extracted fields, extended immediate, control signals
module decode_ctrl_gen
    import decoder_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH    = 16,
    parameter int unsigned OPCODE_WIDTH   = 4,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned IMM_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned IMM_SIGNED     = 0
) (
    input  logic [INSTR_WIDTH-1:0] instruction,
    output decode_bundle_t         bundle
);

    if (OPCODE_WIDTH + 3 * REG_ADDR_WIDTH > INSTR_WIDTH ||
        IMM_WIDTH > INSTR_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH ||
        OPCODE_WIDTH < 4 || REG_ADDR_WIDTH < 3 || REG_ADDR_WIDTH > MAX_REG_ADDR_WIDTH ||
        DATA_WIDTH < IMM_WIDTH || DATA_WIDTH > MAX_DATA_WIDTH || IMM_WIDTH == 0) begin : g_bad_cfg
        $error("pipelined_instruction_decoder: inconsistent field widths");
    end

    localparam int unsigned RD_LSB = INSTR_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH;
    localparam int unsigned RS_LSB = RD_LSB - REG_ADDR_WIDTH;
    localparam int unsigned RT_LSB = RS_LSB - REG_ADDR_WIDTH;

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [3:0]                op_low;
    logic                      op_upper_set;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [IMM_WIDTH-1:0]      imm;
    logic [MAX_DATA_WIDTH-1:0] imm_ext;

    assign opcode       = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign op_low       = opcode[3:0];
    assign op_upper_set = (opcode >> 4) != '0;
    assign rd           = instruction[RD_LSB +: REG_ADDR_WIDTH];
    assign rs           = instruction[RS_LSB +: REG_ADDR_WIDTH];
    assign rt           = instruction[RT_LSB +: REG_ADDR_WIDTH];
    assign imm          = instruction[IMM_WIDTH-1:0];

    // Extend to the bundle's full width; the top slices DATA_WIDTH back out.
    assign imm_ext = (IMM_SIGNED != 0) ? MAX_DATA_WIDTH'($signed(imm))
                                       : MAX_DATA_WIDTH'(imm);

    always_comb begin
        bundle            = '0;
        bundle.rd_address = MAX_REG_ADDR_WIDTH'(rd);
        bundle.rs_address = MAX_REG_ADDR_WIDTH'(rs);
        bundle.rt_address = MAX_REG_ADDR_WIDTH'(rt);
        bundle.nzp        = rd[REG_ADDR_WIDTH-1 -: 3];
        bundle.immediate  = imm_ext;

        if (op_upper_set) begin
            bundle.illegal = 1'b1;
        end else begin
            case (op_low)
                OP_NOP:   ;
                OP_BRNZP: bundle.pc_mux = PC_MUX_BRANCH;
                OP_CMP: begin
                    bundle.alu_output_mux   = 1'b1;
                    bundle.nzp_write_enable = 1'b1;
                end
                OP_ADD: begin
                    bundle.reg_write_enable   = 1'b1;
                    bundle.alu_arithmetic_mux = ALU_ADD;
                end
                OP_SUB: begin
                    bundle.reg_write_enable   = 1'b1;
                    bundle.alu_arithmetic_mux = ALU_SUB;
                end
                OP_MUL: begin
                    bundle.reg_write_enable   = 1'b1;
                    bundle.alu_arithmetic_mux = ALU_MUL;
                end
                OP_DIV: begin
                    bundle.reg_write_enable   = 1'b1;
                    bundle.alu_arithmetic_mux = ALU_DIV;
                end
                OP_LDR: begin
                    bundle.reg_write_enable = 1'b1;
                    bundle.mem_read_enable  = 1'b1;
                    bundle.reg_input_mux    = REG_IN_MEM;
                end
                OP_STR:   bundle.mem_write_enable = 1'b1;
                OP_CONST: begin
                    bundle.reg_write_enable = 1'b1;
                    bundle.reg_input_mux    = REG_IN_IMM;
                end
                OP_JMP:   bundle.pc_mux = PC_MUX_JUMP;
                OP_RET:   bundle.ret    = 1'b1;
                default:  bundle.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Handshaked instruction decoder with a two-entry skid buffer.
// Ports:
//   clk, reset_n            clock; asynchronous active-low reset
//   flush                   drops held entries and any same-cycle input
//   in_valid/in_ready       fetcher handshake (in_ready is registered)
//   instruction             raw instruction word
//   out_valid/out_ready     execute-stage handshake
//   decoded_*               registered decoded fields and controls of the head entry
module pipelined_instruction_decoder
    import decoder_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH    = 16,
    parameter int unsigned OPCODE_WIDTH   = 4,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned IMM_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned IMM_SIGNED     = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_WIDTH-1:0]    instruction,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] decoded_rd_address,
    output logic [REG_ADDR_WIDTH-1:0] decoded_rs_address,
    output logic [REG_ADDR_WIDTH-1:0] decoded_rt_address,
    output logic [2:0]                decoded_nzp,
    output logic [DATA_WIDTH-1:0]     decoded_immediate,
    output logic                      decoded_reg_write_enable,
    output logic                      decoded_mem_read_enable,
    output logic                      decoded_mem_write_enable,
    output logic                      decoded_nzp_write_enable,
    output logic [1:0]                decoded_reg_input_mux,
    output logic [1:0]                decoded_alu_arithmetic_mux,
    output logic                      decoded_alu_output_mux,
    output logic [1:0]                decoded_pc_mux,
    output logic                      decoded_ret,
    output logic                      decoded_illegal
);

    decode_bundle_t new_bundle;
    decode_bundle_t out_q, out_d, skid_q, skid_d;
    logic           out_valid_q, out_valid_d;
    logic           skid_valid_q, skid_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           accept;
    logic           out_free;

    decode_ctrl_gen #(
        .INSTR_WIDTH   (INSTR_WIDTH),
        .OPCODE_WIDTH  (OPCODE_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .IMM_WIDTH     (IMM_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .IMM_SIGNED    (IMM_SIGNED)
    ) u_decode_ctrl_gen (
        .instruction(instruction),
        .bundle     (new_bundle)
    );

    assign accept   = in_valid && in_ready_q && !flush;
    // OUT can take a new entry this edge if it is empty or being consumed.
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older SKID entry advances first to keep FIFO order.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = new_bundle;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = new_bundle;
            end
        end else if (accept) begin
            skid_d       = new_bundle;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    assign decoded_rd_address         = out_q.rd_address[REG_ADDR_WIDTH-1:0];
    assign decoded_rs_address         = out_q.rs_address[REG_ADDR_WIDTH-1:0];
    assign decoded_rt_address         = out_q.rt_address[REG_ADDR_WIDTH-1:0];
    assign decoded_nzp                = out_q.nzp;
    assign decoded_immediate          = out_q.immediate[DATA_WIDTH-1:0];
    assign decoded_reg_write_enable   = out_q.reg_write_enable;
    assign decoded_mem_read_enable    = out_q.mem_read_enable;
    assign decoded_mem_write_enable   = out_q.mem_write_enable;
    assign decoded_nzp_write_enable   = out_q.nzp_write_enable;
    assign decoded_reg_input_mux      = out_q.reg_input_mux;
    assign decoded_alu_arithmetic_mux = out_q.alu_arithmetic_mux;
    assign decoded_alu_output_mux     = out_q.alu_output_mux;
    assign decoded_pc_mux             = out_q.pc_mux;
    assign decoded_ret                = out_q.ret;
    assign decoded_illegal            = out_q.illegal;

    // Padding bits above the configured widths are never driven out.
    logic unused_pad;
    assign unused_pad = ^out_q;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
module tb_pipelined_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] instruction;

    always #5 clk = ~clk;

    // Three instances: defaults, 16-bit zero-extend, 16-bit sign-extend.
    logic        ir  [3];
    logic        ov  [3];
    logic [43:0] vec [3];

    logic [3:0]  d_rd, d_rs, d_rt;  logic [2:0] d_nzp;  logic [7:0]  d_imm;
    logic [3:0]  z_rd, z_rs, z_rt;  logic [2:0] z_nzp;  logic [15:0] z_imm;
    logic [3:0]  s_rd, s_rs, s_rt;  logic [2:0] s_nzp;  logic [15:0] s_imm;
    logic        d_rwe, d_mre, d_mwe, d_nwe, d_aom, d_ret, d_ill;
    logic        z_rwe, z_mre, z_mwe, z_nwe, z_aom, z_ret, z_ill;
    logic        s_rwe, s_mre, s_mwe, s_nwe, s_aom, s_ret, s_ill;
    logic [1:0]  d_rim, d_aam, d_pc, z_rim, z_aam, z_pc, s_rim, s_aam, s_pc;

    pipelined_instruction_decoder u_dut_d (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .instruction(instruction), .out_valid(ov[0]), .out_ready(out_ready),
        .decoded_rd_address(d_rd), .decoded_rs_address(d_rs), .decoded_rt_address(d_rt),
        .decoded_nzp(d_nzp), .decoded_immediate(d_imm),
        .decoded_reg_write_enable(d_rwe), .decoded_mem_read_enable(d_mre),
        .decoded_mem_write_enable(d_mwe), .decoded_nzp_write_enable(d_nwe),
        .decoded_reg_input_mux(d_rim), .decoded_alu_arithmetic_mux(d_aam),
        .decoded_alu_output_mux(d_aom), .decoded_pc_mux(d_pc), .decoded_ret(d_ret),
        .decoded_illegal(d_ill)
    );

    pipelined_instruction_decoder #(.DATA_WIDTH(16), .IMM_SIGNED(0)) u_dut_z (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .instruction(instruction), .out_valid(ov[1]), .out_ready(out_ready),
        .decoded_rd_address(z_rd), .decoded_rs_address(z_rs), .decoded_rt_address(z_rt),
        .decoded_nzp(z_nzp), .decoded_immediate(z_imm),
        .decoded_reg_write_enable(z_rwe), .decoded_mem_read_enable(z_mre),
        .decoded_mem_write_enable(z_mwe), .decoded_nzp_write_enable(z_nwe),
        .decoded_reg_input_mux(z_rim), .decoded_alu_arithmetic_mux(z_aam),
        .decoded_alu_output_mux(z_aom), .decoded_pc_mux(z_pc), .decoded_ret(z_ret),
        .decoded_illegal(z_ill)
    );

    pipelined_instruction_decoder #(.DATA_WIDTH(16), .IMM_SIGNED(1)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .instruction(instruction), .out_valid(ov[2]), .out_ready(out_ready),
        .decoded_rd_address(s_rd), .decoded_rs_address(s_rs), .decoded_rt_address(s_rt),
        .decoded_nzp(s_nzp), .decoded_immediate(s_imm),
        .decoded_reg_write_enable(s_rwe), .decoded_mem_read_enable(s_mre),
        .decoded_mem_write_enable(s_mwe), .decoded_nzp_write_enable(s_nwe),
        .decoded_reg_input_mux(s_rim), .decoded_alu_arithmetic_mux(s_aam),
        .decoded_alu_output_mux(s_aom), .decoded_pc_mux(s_pc), .decoded_ret(s_ret),
        .decoded_illegal(s_ill)
    );

    assign vec[0] = {d_rd, d_rs, d_rt, d_nzp, 8'h00, d_imm, d_rwe, d_mre, d_mwe, d_nwe,
                     d_rim, d_aam, d_aom, d_pc, d_ret, d_ill};
    assign vec[1] = {z_rd, z_rs, z_rt, z_nzp, z_imm, z_rwe, z_mre, z_mwe, z_nwe,
                     z_rim, z_aam, z_aom, z_pc, z_ret, z_ill};
    assign vec[2] = {s_rd, s_rs, s_rt, s_nzp, s_imm, s_rwe, s_mre, s_mwe, s_nwe,
                     s_rim, s_aam, s_aom, s_pc, s_ret, s_ill};

    int checks = 0;
    int errors = 0;

    // Reference model: the decoder is a FIFO of capacity two.
    logic [15:0] mq[$];
    logic        m_in_ready;
    logic        accepted;

    // Expected bundle from the opcode table. mode 0: 8-bit zero-ext,
    // 1: 16-bit zero-ext, 2: 16-bit sign-ext.
    function automatic logic [43:0] model_bundle(input logic [15:0] ins, input int mode);
        logic [3:0]  op;
        logic [15:0] imm;
        logic        rwe, mre, mwe, nwe, aom, ret, ill;
        logic [1:0]  rim, aam, pc;
        op = ins[15:12];
        {rwe, mre, mwe, nwe, aom, ret, ill} = '0;
        {rim, aam, pc} = '0;
        imm = (mode == 2) ? {{8{ins[7]}}, ins[7:0]} : {8'h00, ins[7:0]};
        case (op)
            4'h1: pc = 2'd1;
            4'h2: begin aom = 1'b1; nwe = 1'b1; end
            4'h3, 4'h4, 4'h5, 4'h6: begin rwe = 1'b1; aam = 2'(op - 4'd3); end
            4'h7: begin rwe = 1'b1; mre = 1'b1; rim = 2'b01; end
            4'h8: mwe = 1'b1;
            4'h9: begin rwe = 1'b1; rim = 2'b10; end
            4'hA: pc = 2'd2;
            4'hF: ret = 1'b1;
            4'hB, 4'hC, 4'hD, 4'hE: ill = 1'b1;
            default: ;
        endcase
        return {ins[11:8], ins[7:4], ins[3:0], ins[11:9], imm, rwe, mre, mwe, nwe,
                rim, aam, aom, pc, ret, ill};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(m_in_ready));
            chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(mq.size() > 0));
            if (mq.size() > 0)
                chk($sformatf("bundle[%0d] instr %h", i, mq[0]), 64'(vec[i]),
                    64'(model_bundle(mq[0], i)));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s in_ready[%0d]", tag, i), 64'(ir[i]), 64'd1);
            chk($sformatf("%s out_valid[%0d]", tag, i), 64'(ov[i]), 64'd0);
            chk($sformatf("%s bundle[%0d]", tag, i), 64'(vec[i]), 64'd0);
        end
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        accepted = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (in_valid && m_in_ready) begin
                mq.push_back(instruction);
                accepted = 1'b1;
            end
        end
        m_in_ready = (mq.size() < 2);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [15:0] ins);
        in_valid    = 1'b1;
        instruction = ins;
        cycle();
        in_valid = 1'b0;
    endtask

    logic [15:0] stream [4];
    int          idx;
    int          ready_low;

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = '0;
        m_in_ready  = 1'b1;
        accepted    = 1'b0;
        #12;
        check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // ADD r1, r2, r3 with execute stage ready
        out_ready = 1'b1;
        send(16'h3123);
        chk("add rd", 64'(d_rd), 64'd1);
        chk("add rs", 64'(d_rs), 64'd2);
        chk("add rt", 64'(d_rt), 64'd3);
        chk("add reg_we", 64'(d_rwe), 64'd1);
        chk("add arith", 64'(d_aam), 64'd0);
        chk("add illegal", 64'(d_ill), 64'd0);
        cycle();

        // CONST with negative immediate
        send(16'h94F0);
        chk("const rd", 64'(s_rd), 64'd4);
        chk("const imm signed", 64'(s_imm), 64'hFFF0);
        chk("const imm zero", 64'(z_imm), 64'h00F0);
        chk("const input_mux", 64'(s_rim), 64'd2);
        cycle();

        // Back-to-back stream with a two-cycle stall
        stream[0] = 16'h0000; stream[1] = 16'h3123;
        stream[2] = 16'h4456; stream[3] = 16'h8789;
        idx = 0;
        ready_low = 0;
        for (int c = 0; c < 12 && idx < 4; c++) begin
            in_valid    = 1'b1;
            instruction = stream[idx];
            out_ready   = !(c == 1 || c == 2);
            cycle();
            if (accepted) idx++;
            if (!ir[0]) ready_low++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream all accepted", 64'(idx), 64'd4);
        chk("stream in_ready stalled", 64'(ready_low > 0), 64'd1);
        for (int c = 0; c < 3; c++) cycle();

        // Illegal opcode, then RET
        send(16'hB000);
        chk("illegal flag", 64'(d_ill), 64'd1);
        chk("illegal enables", 64'({d_rwe, d_mre, d_mwe, d_nwe, d_ret, d_pc}), 64'd0);
        send(16'hF000);
        chk("ret flag", 64'(d_ret), 64'd1);
        chk("ret illegal", 64'(d_ill), 64'd0);
        cycle();

        // Fill both entries then flush with a valid input present
        out_ready = 1'b0;
        send(16'h3111);
        send(16'h4222);
        chk("full in_ready", 64'(ir[0]), 64'd0);
        flush       = 1'b1;
        in_valid    = 1'b1;
        instruction = 16'h5333;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", 64'(ov[0]), 64'd0);
        chk("flush in_ready", 64'(ir[0]), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) cycle();

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            instruction = 16'($urandom);
            cycle();
        end

        // Reset mid-stream between clock edges
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instruction = 16'h7ABC;
        cycle();
        instruction = 16'h2DEF;
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("midreset");
        mq.delete();
        m_in_ready = 1'b1;
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send(16'h5A5F);
        chk("post-reset rd", 64'(d_rd), 64'hA);
        chk("post-reset arith", 64'(d_aam), 64'd2);
        for (int c = 0; c < 2; c++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
